// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave with synchronized inputs, one-word tx holding register and word-wide rx
`timescale 1ns/1ps
module spi_slave #(
    parameter int               DW   = 8,
    parameter logic             CPOL = 1'b0,
    parameter logic             CPHA = 1'b0,
    parameter logic [DW-1:0]    DEF  = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            sclk_i,
    input  logic            mosi_i,
    input  logic            ss_i,
    output logic            miso_o,
    output logic            miso_t,
    input  logic [DW-1:0]   tx_dat_i,
    input  logic            tx_vld_i,
    output logic            tx_rdy_o,
    output logic [DW-1:0]   rx_dat_o,
    output logic            rx_vld_o,
    output logic            tx_unf_o,
    output logic            busy_o
);

    localparam int              CW   = $clog2(DW);
    localparam logic [CW-1:0]   LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;

    logic           r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic           r_ss_meta, r_ss_sync, r_ss_prev;
    logic           r_mosi_meta, r_mosi_sync;
    logic [1:0]     r_settle;

    logic [DW-1:0]  r_tx_sh;
    logic [DW-1:0]  r_hold;
    logic           r_hold_full;
    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_rx_sh;
    logic [DW-1:0]  r_rx_dat;
    logic           r_rx_vld;
    logic           r_tx_unf;
    logic           r_miso_t;

    logic           w_lead, w_trail, w_sclk_sample, w_sclk_shift;
    logic           w_ss_fall, w_ss_rise;
    logic           w_start, w_stop, w_sample, w_shift;
    logic           w_last, w_wrap, w_load, w_tx_shift, w_accept;

    // Two-flop synchronizers plus one history flop for edge detection; settle counter
    // keeps WAIT_IDLE from trusting the reset value of the ss synchronizer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sclk_meta <= CPOL;
            r_sclk_sync <= CPOL;
            r_sclk_prev <= CPOL;
            r_ss_meta   <= 1'b1;
            r_ss_sync   <= 1'b1;
            r_ss_prev   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_settle    <= 2'd0;
        end else begin
            r_sclk_meta <= sclk_i;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_ss_meta   <= ss_i;
            r_ss_sync   <= r_ss_meta;
            r_ss_prev   <= r_ss_sync;
            r_mosi_meta <= mosi_i;
            r_mosi_sync <= r_mosi_meta;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    assign w_lead        = (r_sclk_prev == CPOL) && (r_sclk_sync != CPOL);
    assign w_trail       = (r_sclk_prev != CPOL) && (r_sclk_sync == CPOL);
    assign w_sclk_sample = CPHA ? w_trail : w_lead;
    assign w_sclk_shift  = CPHA ? w_lead  : w_trail;
    assign w_ss_fall     = r_ss_prev & ~r_ss_sync;
    assign w_ss_rise     = ~r_ss_prev & r_ss_sync;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= WAIT_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and per-cycle frame events; SPI edges only count while ACTIVE.
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_stop     = 1'b0;
        w_sample   = 1'b0;
        w_shift    = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if ((r_settle == 2'd3) && r_ss_sync) begin
                    w_state_nx = IDLE;
                end
            end
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_nx = ACTIVE;
                    w_start    = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_nx = IDLE;
                    w_stop     = 1'b1;
                end else begin
                    w_sample   = w_sclk_sample;
                    w_shift    = w_sclk_shift;
                end
            end
            default: begin
                w_state_nx = WAIT_IDLE;
            end
        endcase
    end

    // A shift edge at count 0 is the word boundary: CPHA=0 loads there, CPHA=1 holds
    // the MSB that was loaded on the last sample edge of the previous word.
    assign w_last     = (r_cnt == LAST);
    assign w_wrap     = w_sample & w_last;
    assign w_load     = w_start | (CPHA ? w_wrap : (w_shift && (r_cnt == '0)));
    assign w_tx_shift = w_shift && (r_cnt != '0);
    assign w_accept   = tx_vld_i & ~r_hold_full;

    // Tx holding/shift registers, bit counter, rx assembly and output pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_sh     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_rx_sh     <= '0;
            r_rx_dat    <= '0;
            r_rx_vld    <= 1'b0;
            r_tx_unf    <= 1'b0;
            r_miso_t    <= 1'b1;
        end else begin
            r_rx_vld <= 1'b0;
            r_tx_unf <= 1'b0;

            if (w_load) begin
                r_tx_sh  <= r_hold_full ? r_hold : DEF;
                r_tx_unf <= ~r_hold_full;
            end else if (w_tx_shift) begin
                r_tx_sh  <= {r_tx_sh[DW-2:0], 1'b0};
            end

            if (w_accept) begin
                r_hold      <= tx_dat_i;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_start) begin
                r_cnt <= '0;
            end else if (w_sample) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end

            if (w_sample) begin
                r_rx_sh <= {r_rx_sh[DW-2:0], r_mosi_sync};
                if (w_last) begin
                    r_rx_dat <= {r_rx_sh[DW-2:0], r_mosi_sync};
                    r_rx_vld <= 1'b1;
                end
            end

            if (w_start) begin
                r_miso_t <= 1'b0;
            end else if (w_stop) begin
                r_miso_t <= 1'b1;
            end
        end
    end

    assign miso_o   = r_tx_sh[DW-1];
    assign miso_t   = r_miso_t;
    assign tx_rdy_o = ~r_hold_full;
    assign rx_dat_o = r_rx_dat;
    assign rx_vld_o = r_rx_vld;
    assign tx_unf_o = r_tx_unf;
    assign busy_o   = (r_state == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed scoreboard bench for spi_slave in mode 0 and mode 3
`timescale 1ns/1ps
module tb_spi_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sclk0 = 1'b0, mosi0 = 1'b0, ss0 = 1'b1;
    logic       miso0, misot0, txr0, rxv0, unf0, busy0;
    logic [7:0] txd0 = 8'h00;
    logic       txv0 = 1'b0;
    logic [7:0] rxd0;

    logic       sclk3 = 1'b1, mosi3 = 1'b0, ss3 = 1'b1;
    logic       miso3, misot3, txr3, rxv3, unf3, busy3;
    logic [7:0] txd3 = 8'h00;
    logic       txv3 = 1'b0;
    logic [7:0] rxd3;

    spi_slave #(.DW(8), .CPOL(1'b0), .CPHA(1'b0), .DEF(8'h00)) u_m0 (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk0), .mosi_i(mosi0), .ss_i(ss0),
        .miso_o(miso0), .miso_t(misot0), .tx_dat_i(txd0), .tx_vld_i(txv0),
        .tx_rdy_o(txr0), .rx_dat_o(rxd0), .rx_vld_o(rxv0), .tx_unf_o(unf0),
        .busy_o(busy0)
    );

    spi_slave #(.DW(8), .CPOL(1'b1), .CPHA(1'b1), .DEF(8'h00)) u_m3 (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk3), .mosi_i(mosi3), .ss_i(ss3),
        .miso_o(miso3), .miso_t(misot3), .tx_dat_i(txd3), .tx_vld_i(txv3),
        .tx_rdy_o(txr3), .rx_dat_o(rxd3), .rx_vld_o(rxv3), .tx_unf_o(unf3),
        .busy_o(busy3)
    );

    int n_chk = 0;
    int n_err = 0;
    int nrx0 = 0, nrx3 = 0, nunf0 = 0, nunf3 = 0;

    logic [7:0] feed0[$], feed3[$];
    logic [7:0] rxq0[$], rxq3[$];
    logic [7:0] txq0[$], txq3[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor outputs at the falling edge, then drive tx feeders.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (rxv0) begin
            nrx0++;
            if (rxq0.size() > 0) check("rx0_word", rxd0, rxq0.pop_front());
            else                 check("rx0_spurious_vld", rxv0, 0);
        end
        if (rxv3) begin
            nrx3++;
            if (rxq3.size() > 0) check("rx3_word", rxd3, rxq3.pop_front());
            else                 check("rx3_spurious_vld", rxv3, 0);
        end
        if (unf0) nunf0++;
        if (unf3) nunf3++;
        txv0 = 1'b0;
        if (!rst && feed0.size() > 0 && txr0) begin
            txd0 = feed0.pop_front();
            txv0 = 1'b1;
        end
        txv3 = 1'b0;
        if (!rst && feed3.size() > 0 && txr3) begin
            txd3 = feed3.pop_front();
            txv3 = 1'b1;
        end
    endtask

    // Mode 0 master: mosi set before the rising (sample) edge, miso read at it.
    task automatic m0_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi0 = mo[7-i];
            repeat (4) step();
            mi[7-i] = miso0;
            sclk0 = 1'b1;
            repeat (4) step();
            sclk0 = 1'b0;
        end
    endtask

    // Mode 3 master: falling edge launches, rising edge samples.
    task automatic m3_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sclk3 = 1'b0;
            mosi3 = mo[7-i];
            repeat (4) step();
            mi[7-i] = miso3;
            sclk3 = 1'b1;
            repeat (4) step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi;

        // Reset state
        repeat (3) step();
        check("rst_miso_t", misot0, 1);
        check("rst_miso", miso0, 0);
        check("rst_tx_rdy", txr0, 1);
        check("rst_rx_dat", rxd0, 8'h00);
        check("rst_rx_vld", rxv0, 0);
        check("rst_tx_unf", unf0, 0);
        check("rst_busy", busy0, 0);
        check("rst3_miso_t", misot3, 1);
        check("rst3_miso", miso3, 0);
        rst = 1'b0;
        repeat (10) step();

        // Mode 0: preloaded 0xA5 out, 0x3C in
        feed0.push_back(8'hA5);
        txq0.push_back(8'hA5);
        for (int i = 0; i < 10 && txr0; i++) step();
        check("A_preload_taken", txr0, 0);
        rxq0.push_back(8'h3C);
        nrx0 = 0;
        ss0 = 1'b0;
        repeat (8) step();
        check("A_busy", busy0, 1);
        check("A_miso_t_drive", misot0, 0);
        check("A_tx_rdy_after_start", txr0, 1);
        m0_bits(8'h3C, 8, mi);
        check("A_miso_word", mi, txq0.pop_front());
        repeat (8) step();
        ss0 = 1'b1;
        repeat (8) step();
        check("A_rx_pulses", nrx0, 1);
        check("A_rx_dat_held", rxd0, 8'h3C);
        check("A_miso_t_release", misot0, 1);
        check("A_busy_end", busy0, 0);

        // Mode 0: empty holding register, DEF shifted out
        nrx0 = 0;
        nunf0 = 0;
        txq0.push_back(8'h00);
        rxq0.push_back(8'h96);
        ss0 = 1'b0;
        repeat (8) step();
        check("B_unf_at_start", nunf0, 1);
        m0_bits(8'h96, 8, mi);
        check("B_miso_def", mi, txq0.pop_front());
        repeat (8) step();
        ss0 = 1'b1;
        repeat (8) step();
        check("B_rx_pulses", nrx0, 1);

        // Mode 0: abort after 5 bits, then a clean 0x55 frame
        nrx0 = 0;
        ss0 = 1'b0;
        repeat (8) step();
        m0_bits(8'hB7, 5, mi);
        repeat (4) step();
        ss0 = 1'b1;
        repeat (8) step();
        check("C_abort_no_vld", nrx0, 0);
        check("C_abort_miso_t", misot0, 1);
        check("C_abort_busy", busy0, 0);
        check("C_abort_rx_held", rxd0, 8'h96);
        rxq0.push_back(8'h55);
        ss0 = 1'b0;
        repeat (8) step();
        m0_bits(8'h55, 8, mi);
        repeat (8) step();
        ss0 = 1'b1;
        repeat (8) step();
        check("C_next_rx_pulses", nrx0, 1);
        check("C_next_rx_dat", rxd0, 8'h55);

        // Mode 3: two-word frame, tx words fed as tx_rdy rises (third keeps register full)
        feed3.push_back(8'h81);
        for (int i = 0; i < 10 && txr3; i++) step();
        check("E_preload_taken", txr3, 0);
        txq3.push_back(8'h81);
        txq3.push_back(8'h7E);
        feed3.push_back(8'h7E);
        feed3.push_back(8'h55);
        rxq3.push_back(8'h12);
        rxq3.push_back(8'h34);
        nrx3 = 0;
        nunf3 = 0;
        ss3 = 1'b0;
        repeat (8) step();
        check("E_busy", busy3, 1);
        check("E_miso_t_drive", misot3, 0);
        m3_bits(8'h12, 8, mi);
        check("E_word0", mi, txq3.pop_front());
        m3_bits(8'h34, 8, mi);
        check("E_word1", mi, txq3.pop_front());
        repeat (8) step();
        ss3 = 1'b1;
        repeat (8) step();
        check("E_rx_pulses", nrx3, 2);
        check("E_no_unf", nunf3, 0);
        check("E_rx_dat", rxd3, 8'h34);
        check("E_miso_t_release", misot3, 1);

        // Mode 0: reset mid-frame with ss held low
        nrx0 = 0;
        ss0 = 1'b0;
        repeat (8) step();
        m0_bits(8'hF0, 3, mi);
        rst = 1'b1;
        repeat (2) step();
        check("D_rst_miso_t", misot0, 1);
        check("D_rst_miso", miso0, 0);
        check("D_rst_tx_rdy", txr0, 1);
        check("D_rst_rx_dat", rxd0, 8'h00);
        check("D_rst_rx_vld", rxv0, 0);
        check("D_rst_unf", unf0, 0);
        check("D_rst_busy", busy0, 0);
        rst = 1'b0;
        m0_bits(8'hF0, 8, mi);
        repeat (8) step();
        check("D_ignored_busy", busy0, 0);
        check("D_ignored_no_vld", nrx0, 0);
        check("D_ignored_miso_t", misot0, 1);
        ss0 = 1'b1;
        repeat (10) step();
        rxq0.push_back(8'hC3);
        ss0 = 1'b0;
        repeat (8) step();
        check("D_new_frame_busy", busy0, 1);
        m0_bits(8'hC3, 8, mi);
        repeat (8) step();
        ss0 = 1'b1;
        repeat (8) step();
        check("D_new_rx_pulses", nrx0, 1);
        check("D_new_rx_dat", rxd0, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DW, default 8, word width in bits (legal 4..32).
REQ-002 SHALL have parameter CPOL, default 0, sclk idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter DEF, default all-zeros, DW-bit word shifted out on underrun.
REQ-005 clk_i  in  1  system clock; the only clock; all logic on its rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 sclk_i  in  1  SPI clock from master; asynchronous to clk_i.
REQ-008 mosi_i  in  1  master-out data; asynchronous.
REQ-009 ss_i  in  1  slave select, active low; asynchronous.
REQ-010 miso_o  out  1  slave-out data.
REQ-011 miso_t  out  1  tristate control: 1 = high-Z, 0 = drive miso_o.
REQ-012 tx_dat_i  in  DW  next word to transmit.
REQ-013 tx_vld_i  in  1  tx_dat_i valid.
REQ-014 tx_rdy_o  out  1  tx holding register empty; transfer on tx_vld_i & tx_rdy_o.
REQ-015 rx_dat_o  out  DW  last complete received word; held until the next word completes.
REQ-016 rx_vld_o  out  1  one-cycle pulse, rx_dat_o updated.
REQ-017 tx_unf_o  out  1  one-cycle pulse, DEF loaded because holding register empty.
REQ-018 busy_o  out  1  state = ACTIVE.

Function
REQ-019 sclk_i, mosi_i and ss_i SHALL each pass a 2-flop synchronizer; edges SHALL be detected on the synchronized values (3-cycle input latency); sclk_i frequency SHALL be at most clk_i/8.
REQ-020 Leading edge = sclk leaving CPOL level, trailing edge = return to CPOL; sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
REQ-021 State machine SHALL have states WAIT_IDLE, IDLE and ACTIVE.
REQ-022 WAIT_IDLE -> IDLE when synchronized ss is high; all SPI edges are ignored in WAIT_IDLE.
REQ-023 IDLE -> ACTIVE on synchronized ss falling; in the same cycle: load tx shift register, bit count = 0, miso_t = 0.
REQ-024 ACTIVE -> IDLE on synchronized ss rising, from any bit count: partial rx bits discarded, no rx_vld_o, miso_t = 1 next cycle, the word in the tx shift register is lost.
REQ-025 Tx holding register SHALL be one word deep; tx_rdy_o = 1 when empty; it is accepted from tx_dat_i on handshake and emptied when moved into the shift register.
REQ-026 A word load SHALL take the holding register if full, else DEF with a tx_unf_o pulse.
REQ-027 miso_o SHALL always equal the MSB of the tx shift register; data is MSB first.
REQ-028 On each sample edge the synchronized mosi SHALL shift into the rx register LSB and bit count SHALL increment.
REQ-029 On the DW-th sample edge: rx_dat_o = the assembled word, rx_vld_o = 1 for one cycle, bit count wraps to 0.
REQ-030 Shift edge behaviour: shift tx left by one, except at these points.
REQ-031 If CPHA=0, the first shift edge after wrap SHALL perform a word load instead of a shift.
REQ-032 If CPHA=1, the first shift edge of each word (count 0) SHALL not shift; the word load SHALL occur at the DW-th sample edge.
REQ-033 Handshake acceptance and a word load in the same cycle SHALL both act: the old content loads, the new word is stored, and tx_rdy_o stays 0.

Reset
REQ-034 On rst_i: state WAIT_IDLE, miso_t = 1, miso_o = 0, tx_rdy_o = 1, rx_dat_o = 0, rx_vld_o = 0, tx_unf_o = 0, busy_o = 0, holding register empty, bit count 0, synchronizers = idle levels (ss 1, sclk CPOL).
REQ-035 Reset during ACTIVE SHALL abort the frame; no frame is accepted until ss is observed high.

Verification
REQ-036 Mode 0, DW=8, tx 0xA5 preloaded, master sends 0x3C at clk/8 -> miso bits 1,0,1,0,0,1,0,1; rx_dat_o=0x3C with one rx_vld_o pulse; tx_rdy_o=1 after frame start.
REQ-037 Mode 3 (CPOL=1, CPHA=1), 2-word frame, tx 0x81 then 0x7E supplied as tx_rdy_o rises -> master reads 0x81, 0x7E; two rx_vld_o pulses; no tx_unf_o.
REQ-038 Frame with empty holding register -> miso shifts DEF=0x00, tx_unf_o pulses once at frame start.
REQ-039 ss deasserted after 5 bits -> no rx_vld_o, miso_t=1, next frame receives 0x55 correctly.
REQ-040 rst_i mid-frame while ss stays low -> outputs per REQ-034, remaining sclk edges ignored, rx_vld_o never pulses until ss rises and falls again.
